// File: rtl/lii_pkg.sv
// Shared LII definitions: id width, id type and the lane-slice offset helper.
package lii_pkg;

    localparam int LII_ID_W = 8;

    typedef logic [LII_ID_W-1:0] lii_id_t;

    // Bit offset of lane 'lane' in a packed bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Registered first-word-fall-through FIFO; push is ignored when full, pop when empty.
module lii_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == (AW+1)'(DEPTH));
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        // Pointers are AW bits wide, so increment wraps modulo DEPTH.
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout_o  = mem_q[rptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/lii_stream_adapter.sv
// LII phy <-> kernel lane adapter: dst filter, input fork, output join + FIFO, kernel ce.
// Optional LII_ADAPTER_STATS_EN adds saturating beat/drop/stall counters.
module lii_stream_adapter
    import lii_pkg::*;
#(
    parameter int      NIN        = 2,
    parameter int      NOUT       = 2,
    parameter int      IW         = 256,
    parameter int      OW         = 8,
    parameter int      PW         = 512,
    parameter lii_id_t NODE_ID    = 8'h01,
    parameter lii_id_t PEER_ID    = 8'h00,
    parameter int      OBUF_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [PW-1:0]       lii_in_tdata,
    input  logic                lii_in_tvalid,
    output logic                lii_in_tready,
    input  logic [LII_ID_W-1:0] lii_in_src,
    input  logic [LII_ID_W-1:0] lii_in_dst,
    output logic [PW-1:0]       lii_out_tdata,
    output logic                lii_out_tvalid,
    input  logic                lii_out_tready,
    output logic [LII_ID_W-1:0] lii_out_src,
    output logic [LII_ID_W-1:0] lii_out_dst,
    output logic [NIN*IW-1:0]   k_in_tdata,
    output logic [NIN-1:0]      k_in_tvalid,
    input  logic [NIN-1:0]      k_in_tready,
    input  logic [NOUT*OW-1:0]  k_out_tdata,
    input  logic [NOUT-1:0]     k_out_tvalid,
    output logic [NOUT-1:0]     k_out_tready,
    output logic                ce
`ifdef LII_ADAPTER_STATS_EN
   ,output logic [31:0]         stat_in_beats,
    output logic [31:0]         stat_out_beats,
    output logic [31:0]         stat_dropped,
    output logic [31:0]         stat_stall_cycles
`endif
);
    if (NIN * IW > PW) begin : g_bad_nin
        $error("lii_stream_adapter: NIN*IW exceeds PW");
    end
    if (NOUT * OW > PW) begin : g_bad_nout
        $error("lii_stream_adapter: NOUT*OW exceeds PW");
    end
    if (OBUF_DEPTH < 2 || (OBUF_DEPTH & (OBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lii_stream_adapter: OBUF_DEPTH must be a power of two >= 2");
    end

    logic [NIN-1:0]            done_q, done_d;
    logic [NOUT-1:0]           held_q, held_d;
    logic [NOUT-1:0][OW-1:0]   hdata_q, hdata_d;
    logic                      match, in_acc, push, fifo_full, fifo_empty;
    logic [PW-1:0]             push_word;
    logic                      unused_src;

    assign unused_src  = ^lii_in_src;
    assign lii_out_src = NODE_ID;
    assign lii_out_dst = PEER_ID;
    assign k_in_tdata  = lii_in_tdata[NIN*IW-1:0];

    always_comb begin
        // Fork: each lane takes the beat once; the LII side completes when every lane has.
        match         = (lii_in_dst == NODE_ID);
        k_in_tvalid   = {NIN{lii_in_tvalid & match & arstn}} & ~done_q;
        lii_in_tready = arstn & (~match | (&(done_q | k_in_tready)));
        in_acc        = lii_in_tvalid & lii_in_tready;
        done_d        = in_acc ? '0 : (done_q | (k_in_tvalid & k_in_tready));

        // Join: one register per lane, flushed as a packed word once all are full.
        k_out_tready  = ~held_q & {NOUT{arstn}};
        push          = (&held_q) & ~fifo_full;
        held_d        = push ? '0 : held_q;
        hdata_d       = hdata_q;
        push_word     = '0;
        for (int j = 0; j < NOUT; j++) begin
            push_word[lane_lsb(j, OW) +: OW] = hdata_q[j];
            if (k_out_tvalid[j] & k_out_tready[j]) begin
                held_d[j]  = 1'b1;
                hdata_d[j] = k_out_tdata[lane_lsb(j, OW) +: OW];
            end
        end

        ce = arstn & ~fifo_full & ~(&held_q);
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            done_q  <= '0;
            held_q  <= '0;
            hdata_q <= '0;
        end else begin
            done_q  <= done_d;
            held_q  <= held_d;
            hdata_q <= hdata_d;
        end
    end

    lii_sync_fifo #(.WIDTH(PW), .DEPTH(OBUF_DEPTH)) u_obuf (
        .clk    (aclk),
        .rst_n  (arstn),
        .push_i (push),
        .din_i  (push_word),
        .pop_i  (lii_out_tready & arstn),
        .dout_o (lii_out_tdata),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    assign lii_out_tvalid = ~fifo_empty & arstn;

`ifdef LII_ADAPTER_STATS_EN
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            stat_in_beats     <= '0;
            stat_out_beats    <= '0;
            stat_dropped      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (in_acc & match && stat_in_beats != '1)  stat_in_beats <= stat_in_beats + 32'd1;
            if (in_acc & ~match && stat_dropped != '1)  stat_dropped  <= stat_dropped + 32'd1;
            if (lii_out_tvalid & lii_out_tready && stat_out_beats != '1)
                stat_out_beats <= stat_out_beats + 32'd1;
            if (lii_out_tvalid & ~lii_out_tready && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lii_stream_adapter.sv
// Scoreboard bench for lii_stream_adapter: stimulus pushes expectations, negedge monitor pops.
module tb_lii_stream_adapter;
    localparam int NIN = 2, NOUT = 2, IW = 256, OW = 8, PW = 512;

    logic               aclk = 1'b0;
    logic               arstn;
    logic [PW-1:0]      lii_in_tdata;
    logic               lii_in_tvalid, lii_in_tready;
    logic [7:0]         lii_in_src, lii_in_dst;
    logic [PW-1:0]      lii_out_tdata;
    logic               lii_out_tvalid, lii_out_tready;
    logic [7:0]         lii_out_src, lii_out_dst;
    logic [NIN*IW-1:0]  k_in_tdata;
    logic [NIN-1:0]     k_in_tvalid, k_in_tready;
    logic [NOUT*OW-1:0] k_out_tdata;
    logic [NOUT-1:0]    k_out_tvalid, k_out_tready;
    logic               ce;
`ifdef LII_ADAPTER_STATS_EN
    logic [31:0] stat_in_beats, stat_out_beats, stat_dropped, stat_stall_cycles;
`endif

    always #5 aclk = ~aclk;

    lii_stream_adapter dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid), .lii_in_tready(lii_in_tready),
        .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
        .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid), .lii_out_tready(lii_out_tready),
        .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
        .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
        .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
        .ce(ce)
`ifdef LII_ADAPTER_STATS_EN
       ,.stat_in_beats(stat_in_beats), .stat_out_beats(stat_out_beats),
        .stat_dropped(stat_dropped), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    int errors = 0, checks = 0;
    logic [IW-1:0] q_in0[$], q_in1[$];
    logic [PW-1:0] q_out[$];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event without matching expectation", name);
    endtask

    // Monitor: every handshake on a DUT output is matched against the scoreboard.
    always @(negedge aclk) begin
        if (arstn === 1'b1) begin
            if (k_in_tvalid[0] && k_in_tready[0]) begin
                if (q_in0.size() == 0) miss("lane0_unexpected");
                else chk("lane0_data", PW'(k_in_tdata[IW-1:0]), PW'(q_in0.pop_front()));
            end
            if (k_in_tvalid[1] && k_in_tready[1]) begin
                if (q_in1.size() == 0) miss("lane1_unexpected");
                else chk("lane1_data", PW'(k_in_tdata[2*IW-1:IW]), PW'(q_in1.pop_front()));
            end
            if (lii_out_tvalid && lii_out_tready) begin
                if (q_out.size() == 0) miss("out_unexpected");
                else chk("out_data", lii_out_tdata, q_out.pop_front());
            end
        end
    end

    task automatic send_word(input logic [7:0] l0, input logic [7:0] l1);
        bit sent = 0;
        for (int n = 0; n < 20 && !sent; n++) begin
            @(posedge aclk); #1;
            if (k_out_tready == 2'b11) begin
                k_out_tvalid = 2'b11;
                k_out_tdata  = {l1, l0};
                q_out.push_back({{(PW-16){1'b0}}, l1, l0});
                sent = 1;
                @(posedge aclk); #1;
                k_out_tvalid = '0;
            end
        end
        if (!sent) miss("send_timeout");
    endtask

    initial begin
        arstn = 0; lii_in_tdata = '0; lii_in_tvalid = 1; lii_in_src = 8'h05; lii_in_dst = 8'h01;
        k_in_tready = 2'b11; k_out_tdata = 16'hFFFF; k_out_tvalid = 2'b11; lii_out_tready = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_kin_valid", PW'(k_in_tvalid), 0);
        chk("rst_in_tready", PW'(lii_in_tready), 0);
        chk("rst_kout_tready", PW'(k_out_tready), 0);
        chk("rst_out_tvalid", PW'(lii_out_tvalid), 0);
        chk("rst_ce", PW'(ce), 0);
        chk("out_src", PW'(lii_out_src), PW'(8'h01));
        chk("out_dst", PW'(lii_out_dst), 0);
        @(posedge aclk); #1;
        arstn = 1; lii_in_tvalid = 0; k_out_tvalid = '0;

        // Fork: lane0 ready 3 cycles, then lane1.
        @(posedge aclk); #1;
        lii_in_tdata = {{32{8'hAA}}, {32{8'h55}}}; lii_in_tvalid = 1; k_in_tready = 2'b01;
        q_in0.push_back({32{8'h55}}); q_in1.push_back({32{8'hAA}});
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk("fork_tready_low", PW'(lii_in_tready), 0);
            chk("fork_kvalid", PW'(k_in_tvalid), (c == 0) ? PW'(2'b11) : PW'(2'b10));
            @(posedge aclk); #1;
        end
        k_in_tready = 2'b10;
        @(negedge aclk);
        chk("fork_tready_high", PW'(lii_in_tready), 1);
        chk("fork_kvalid_last", PW'(k_in_tvalid), PW'(2'b10));
        @(posedge aclk); #1;
        lii_in_tvalid = 0; k_in_tready = 2'b11;

        // Foreign beat dropped.
        lii_in_tdata = {64{8'h77}}; lii_in_dst = 8'h07; lii_in_tvalid = 1;
        @(negedge aclk);
        chk("foreign_tready", PW'(lii_in_tready), 1);
        chk("foreign_kvalid", PW'(k_in_tvalid), 0);
        @(posedge aclk); #1;
        lii_in_tvalid = 0; lii_in_dst = 8'h01;
`ifdef LII_ADAPTER_STATS_EN
        @(negedge aclk);
        chk("stat_dropped", PW'(stat_dropped), 1);
`endif

        // Join: lanes complete two cycles apart.
        @(posedge aclk); #1;
        k_out_tdata = 16'h003C; k_out_tvalid = 2'b01;
        @(negedge aclk);
        chk("join_rdy", PW'(k_out_tready), PW'(2'b11));
        @(posedge aclk); #1;
        k_out_tvalid = '0;
        @(negedge aclk);
        chk("join_held0", PW'(k_out_tready), PW'(2'b10));
        @(posedge aclk); #1;
        k_out_tdata = 16'hC300; k_out_tvalid = 2'b10;
        q_out.push_back({{(PW-16){1'b0}}, 16'hC33C});
        @(posedge aclk); #1;
        k_out_tvalid = '0;
        @(negedge aclk);
        chk("join_ce_low", PW'(ce), 0);
        chk("join_not_yet", PW'(lii_out_tvalid), 0);
        @(negedge aclk);
        chk("join_out_valid", PW'(lii_out_tvalid), 1);
        repeat (2) @(posedge aclk);

        // Back-pressure: 4 buffered, 5th held, kernel frozen.
        #1 lii_out_tready = 0;
        for (int k = 1; k <= 5; k++) send_word(8'(k), 8'(8'h10 + k));
        @(negedge aclk);
        chk("full_kout_tready", PW'(k_out_tready), 0);
        chk("full_ce", PW'(ce), 0);
        chk("full_out_valid", PW'(lii_out_tvalid), 1);
        @(posedge aclk); #1;
        lii_out_tready = 1;
        repeat (12) @(posedge aclk);
        chk("drain_all", PW'(q_out.size()), 0);

        // Reset mid-fork after lane0 has taken the beat.
        @(posedge aclk); #1;
        lii_in_tdata = {{32{8'h33}}, {32{8'hCC}}}; lii_in_tvalid = 1; k_in_tready = 2'b01;
        q_in0.push_back({32{8'hCC}});
        @(posedge aclk); #1;
        arstn = 0;
        @(negedge aclk);
        chk("mrst_kvalid", PW'(k_in_tvalid), 0);
        chk("mrst_tready", PW'(lii_in_tready), 0);
        chk("mrst_ce", PW'(ce), 0);
        chk("mrst_kout_tready", PW'(k_out_tready), 0);
        @(posedge aclk); #1;
        arstn = 1; lii_in_tdata = {{32{8'h99}}, {32{8'h66}}}; k_in_tready = 2'b11;
        q_in0.push_back({32{8'h66}}); q_in1.push_back({32{8'h99}});
        @(negedge aclk);
        chk("post_rst_kvalid", PW'(k_in_tvalid), PW'(2'b11));
        chk("post_rst_tready", PW'(lii_in_tready), 1);
        @(posedge aclk); #1;
        lii_in_tvalid = 0;

        repeat (3) @(posedge aclk);
        chk("q_in0_empty", PW'(q_in0.size()), 0);
        chk("q_in1_empty", PW'(q_in1.size()), 0);
        chk("q_out_empty", PW'(q_out.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
